mc_cmd_decoder: RTL and testbench

- Clock-domain front end between the MCU asynchronous parallel bus (mc_ce/mc_we/mc_oe/mc_add/mc_data) and the core.
- Synchronises the bus strobes and decodes bus writes into clean single-cycle strobes. Targets: command register, register-pointer file, peripheral FIFO, state-machine trigger.
- Serves register readback onto the bus.
- Sits directly downstream of the MCU pins and upstream of the register file, BP state machine and FIFOs.

---
 rtl/mc_cmd_decoder.sv | 180 ++++++++++++++++++
 tb/tb_mc_cmd_decoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cmd_decoder.sv
// MCU asynchronous bus front end: strobe synchronisers, write decode into core strobes,
// and (when MC_READBACK_EN is defined) the register readback path onto the bus.
module mc_cmd_decoder #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int REG_COUNT     = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mc_ce,
  input  logic                         mc_we,
  input  logic                         mc_oe,
  input  logic [MC_ADD_WIDTH-1:0]      mc_add,
  input  logic [MC_DATA_WIDTH-1:0]     mc_data_in,
  output logic [MC_DATA_WIDTH-1:0]     mc_data_out,
  output logic                         mc_data_oe,
  output logic                         reg_wr_stb,
  output logic [$clog2(REG_COUNT)-1:0] reg_addr,
  output logic [MC_DATA_WIDTH-1:0]     reg_wr_data,
  input  logic [MC_DATA_WIDTH-1:0]     reg_rd_data,
  output logic                         cmd_stb,
  output logic [7:0]                   cmd_code,
  output logic [MC_DATA_WIDTH-1:0]     cmd_data,
  output logic                         fifo_wr_stb,
  output logic [MC_DATA_WIDTH-1:0]     fifo_wr_data,
  output logic                         trigger_stb
);

  localparam int AW = $clog2(REG_COUNT);

  localparam logic [MC_ADD_WIDTH-1:0] ADDR_DATA = MC_ADD_WIDTH'(0);
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_CMD  = MC_ADD_WIDTH'(1);
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_TRIG = MC_ADD_WIDTH'(3);
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_FIFO = MC_ADD_WIDTH'(7);

  localparam logic [7:0] CMD_SET_POINTER = 8'h0B;
  localparam logic [7:0] CMD_REG_WRITE   = 8'h0C;
  localparam logic [7:0] CMD_REG_READ    = 8'h0D;

  logic [SYNC_STAGES-1:0]   we_sync;
  logic                     we_s;
  logic                     we_s_d;
  logic                     commit;
  logic [MC_ADD_WIDTH-1:0]  cap_add;
  logic [MC_DATA_WIDTH-1:0] cap_data;
  logic                     wr_inc;
  logic                     rd_inc;

  // ce high forces the strobe inactive before it enters the synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) we_sync <= '1;
    else      we_sync <= {we_sync[SYNC_STAGES-2:0], mc_we | mc_ce};
  end

  assign we_s   = we_sync[SYNC_STAGES-1];
  assign commit = we_s & ~we_s_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_s_d       <= 1'b1;
      cap_add      <= '0;
      cap_data     <= '0;
      cmd_code     <= '0;
      cmd_stb      <= 1'b0;
      cmd_data     <= '0;
      reg_wr_stb   <= 1'b0;
      reg_wr_data  <= '0;
      fifo_wr_stb  <= 1'b0;
      fifo_wr_data <= '0;
      trigger_stb  <= 1'b0;
      reg_addr     <= '0;
      wr_inc       <= 1'b0;
    end else begin
      we_s_d <= we_s;
      if (!we_s) begin
        cap_add  <= mc_add;
        cap_data <= mc_data_in;
      end

      cmd_stb     <= 1'b0;
      reg_wr_stb  <= 1'b0;
      fifo_wr_stb <= 1'b0;
      trigger_stb <= 1'b0;
      wr_inc      <= 1'b0;

      if (commit) begin
        case (cap_add)
          ADDR_DATA: begin
            case (cmd_code)
              CMD_SET_POINTER: ;
              CMD_REG_WRITE: begin
                reg_wr_stb  <= 1'b1;
                reg_wr_data <= cap_data;
                wr_inc      <= 1'b1;
              end
              default: begin
                cmd_stb  <= 1'b1;
                cmd_data <= cap_data;
              end
            endcase
          end
          ADDR_CMD:  cmd_code <= cap_data[7:0];
          ADDR_TRIG: trigger_stb <= 1'b1;
          ADDR_FIFO: begin
            fifo_wr_stb  <= 1'b1;
            fifo_wr_data <= cap_data;
          end
          default: ;
        endcase
      end

      // Priority: SET_POINTER, then the post-write increment, then a read increment
      // that is dropped whenever a write commits in the same cycle.
      if (commit && cap_add == ADDR_DATA && cmd_code == CMD_SET_POINTER)
        reg_addr <= cap_data[AW-1:0];
      else if (wr_inc)
        reg_addr <= reg_addr + 1'b1;
      else if (rd_inc && !commit)
        reg_addr <= reg_addr + 1'b1;
    end
  end

`ifdef MC_READBACK_EN
  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} rd_state_t;

  rd_state_t              rd_state;
  logic [SYNC_STAGES-1:0] oe_sync;
  logic                   oe_s;
  logic                   rd_at_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) oe_sync <= '1;
    else      oe_sync <= {oe_sync[SYNC_STAGES-2:0], mc_oe | mc_ce};
  end

  assign oe_s   = oe_sync[SYNC_STAGES-1];
  assign rd_inc = (rd_state == DRIVE) && oe_s && rd_at_zero && (cmd_code == CMD_REG_READ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state    <= IDLE;
      mc_data_out <= '0;
      mc_data_oe  <= 1'b0;
      rd_at_zero  <= 1'b0;
    end else begin
      case (rd_state)
        IDLE: begin
          if (!oe_s) begin
            rd_state   <= DRIVE;
            mc_data_oe <= 1'b1;
            rd_at_zero <= (mc_add == ADDR_DATA);
            case (mc_add)
              ADDR_DATA: mc_data_out <= reg_rd_data;
              ADDR_CMD:  mc_data_out <= MC_DATA_WIDTH'(cmd_code);
              default:   mc_data_out <= '0;
            endcase
          end
        end
        DRIVE: begin
          if (oe_s) begin
            rd_state   <= HOLD;
            mc_data_oe <= 1'b0;
          end
        end
        HOLD:    rd_state <= IDLE;
        default: rd_state <= IDLE;
      endcase
    end
  end
`else
  logic unused_rd_inputs;

  assign mc_data_out      = '0;
  assign mc_data_oe       = 1'b0;
  assign rd_inc           = 1'b0;
  assign unused_rd_inputs = ^{mc_oe, reg_rd_data};
`endif

endmodule

// File: tb/tb_mc_cmd_decoder.sv
// Scoreboard bench for mc_cmd_decoder: random bus writes/reads against a transaction-level
// model; expected strobes are queued at issue time and matched by an independent monitor.
module tb_mc_cmd_decoder;
  localparam int DW = 16;
  localparam int AWB = 6;
  localparam int RC = 16;
  localparam int SS = 2;

  logic          clk, rst, mc_ce, mc_we, mc_oe;
  logic [AWB-1:0] mc_add;
  logic [DW-1:0] mc_data_in, mc_data_out, reg_wr_data, reg_rd_data, cmd_data, fifo_wr_data;
  logic          mc_data_oe, reg_wr_stb, cmd_stb, fifo_wr_stb, trigger_stb;
  logic [3:0]    reg_addr;
  logic [7:0]    cmd_code;

  mc_cmd_decoder #(
    .MC_DATA_WIDTH(DW),
    .MC_ADD_WIDTH(AWB),
    .REG_COUNT(RC),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst(rst), .mc_ce(mc_ce), .mc_we(mc_we), .mc_oe(mc_oe),
    .mc_add(mc_add), .mc_data_in(mc_data_in), .mc_data_out(mc_data_out),
    .mc_data_oe(mc_data_oe), .reg_wr_stb(reg_wr_stb), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .cmd_stb(cmd_stb),
    .cmd_code(cmd_code), .cmd_data(cmd_data), .fifo_wr_stb(fifo_wr_stb),
    .fifo_wr_data(fifo_wr_data), .trigger_stb(trigger_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] regfile [RC];
  assign reg_rd_data = regfile[reg_addr];

  // kind: 0 register write, 1 command, 2 fifo push, 3 trigger
  typedef struct {
    int          kind;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [7:0]  code;
    int unsigned cyc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;

  logic [7:0] m_cmd = 8'h00;
  logic [3:0] m_ptr = 4'h0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    int   n;
    int   kind;
    exp_t e;
    n = int'(reg_wr_stb) + int'(cmd_stb) + int'(fifo_wr_stb) + int'(trigger_stb);
    if (n > 0) begin
      if (n > 1) chk("single_strobe", n, 1);
      kind = reg_wr_stb ? 0 : cmd_stb ? 1 : fifo_wr_stb ? 2 : 3;
      if (expq.size() == 0) begin
        chk("unexpected_strobe", {reg_wr_stb, cmd_stb, fifo_wr_stb, trigger_stb}, 0);
      end else begin
        e = expq.pop_front();
        chk("strobe_kind", kind, e.kind);
        chk("strobe_latency", cyc, e.cyc);
        case (e.kind)
          0: begin
            chk("reg_wr_addr", reg_addr, e.addr);
            chk("reg_wr_data", reg_wr_data, e.data);
          end
          1: begin
            chk("cmd_data", cmd_data, e.data);
            chk("cmd_code_at_stb", cmd_code, e.code);
          end
          2: chk("fifo_wr_data", fifo_wr_data, e.data);
          default: ;
        endcase
      end
    end
  end

  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    exp_t e;
    @(posedge clk); #1;
    mc_ce = 1'b0; mc_add = a; mc_data_in = d; mc_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 mc_we = 1'b1;
    e.kind = -1; e.addr = m_ptr; e.data = d; e.code = m_cmd;
    e.cyc = cyc + SS + 1;
    case (a)
      6'h01: m_cmd = d[7:0];
      6'h00: begin
        if (m_cmd == 8'h0B) m_ptr = d[3:0];
        else if (m_cmd == 8'h0C) begin
          e.kind = 0;
          m_ptr = 4'((int'(m_ptr) + 1) % RC);
        end else e.kind = 1;
      end
      6'h03: e.kind = 3;
      6'h07: e.kind = 2;
      default: ;
    endcase
    if (e.kind >= 0) expq.push_back(e);
    repeat (3) @(posedge clk);
    #1 mc_ce = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reg_addr_after_wr", reg_addr, m_ptr);
    chk("cmd_code_after_wr", cmd_code, m_cmd);
  endtask

  task automatic bus_read(input logic [5:0] a);
    int          hi;
    logic [15:0] seen;
    logic [15:0] expd;
    expd = (a == 6'h00) ? regfile[m_ptr] : (a == 6'h01) ? {8'h00, m_cmd} : 16'h0000;
    hi = 0;
    seen = '0;
    @(posedge clk); #1;
    mc_ce = 1'b0; mc_add = a; mc_oe = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 5) mc_oe = 1'b1;
      if (mc_data_oe) hi++;
      if (mc_data_oe) seen = mc_data_out;
`ifndef MC_READBACK_EN
      seen = seen | mc_data_out;
`endif
    end
    mc_ce = 1'b1;
`ifdef MC_READBACK_EN
    chk("read_oe_cycles", hi, 6);
    chk("read_data", seen, expd);
    if (m_cmd == 8'h0D && a == 6'h00) m_ptr = m_ptr + 4'd1;
`else
    chk("read_oe_cycles", hi, 0);
    chk("read_data_tied", seen, 16'h0000);
`endif
    repeat (2) @(posedge clk);
    #1 chk("reg_addr_after_rd", reg_addr, m_ptr);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && expq.size() > 0; i++) @(posedge clk);
    #1 chk("queue_drained", expq.size(), 0);
  endtask

  initial begin
    logic [15:0] d;
    logic [5:0]  a;
    int          r;
    logic [7:0]  codes [5];

    for (int i = 0; i < RC; i++) regfile[i] = 16'($urandom);
    rst = 1'b0; mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1;
    mc_add = '0; mc_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_cmd_code", cmd_code, 0);
    chk("rst_strobes", {reg_wr_stb, cmd_stb, fifo_wr_stb, trigger_stb, mc_data_oe}, 0);
    chk("rst_data_out", mc_data_out, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    bus_write(6'h01, 16'h000B);
    bus_write(6'h00, 16'h0005);
    chk("set_pointer_5", reg_addr, 4'd5);

    bus_write(6'h01, 16'h000B);
    bus_write(6'h00, 16'h0000);
    bus_write(6'h01, 16'h000C);
    bus_write(6'h00, 16'h00FF);
    bus_write(6'h00, 16'h0000);
    bus_write(6'h00, 16'h0001);
    chk("reg_write_ptr_3", reg_addr, 4'd3);

    bus_write(6'h01, 16'h000B);
    bus_write(6'h00, 16'h000F);
    bus_write(6'h01, 16'h000C);
    bus_write(6'h00, 16'hABCD);
    bus_write(6'h00, 16'hABCD);
    chk("reg_write_wrap_ptr", reg_addr, 4'd1);

    bus_write(6'h01, 16'h0008);
    bus_write(6'h00, 16'h0001);
    bus_write(6'h03, 16'h0000);
    bus_write(6'h07, 16'h08AA);

    bus_write(6'h01, 16'h000B);
    bus_write(6'h00, 16'h0002);
    bus_write(6'h01, 16'h000D);
    regfile[2] = 16'h1234;
    bus_read(6'h00);
    bus_read(6'h01);
    bus_read(6'h05);

    codes[0] = 8'h0B; codes[1] = 8'h0C; codes[2] = 8'h0D; codes[3] = 8'h08; codes[4] = 8'h00;
    for (int it = 0; it < 70; it++) begin
      r = $urandom_range(0, 9);
      d = 16'($urandom);
      if (r <= 1) begin
        codes[4] = 8'($urandom);
        d[7:0] = codes[$urandom_range(0, 4)];
        bus_write(6'h01, d);
      end else if (r <= 5) bus_write(6'h00, d);
      else if (r == 6) bus_write(6'h03, d);
      else if (r == 7) bus_write(6'h07, d);
      else if (r == 8) begin
        a = 6'($urandom_range(2, 63));
        if (a == 6'h03 || a == 6'h07) a = 6'h02;
        bus_write(a, d);
      end else begin
        r = $urandom_range(0, 2);
        a = (r == 0) ? 6'h00 : (r == 1) ? 6'h01 : 6'h2A;
        bus_read(a);
      end
    end
    wait_drain();

    // reset lands one clock after we rises: the pending FIFO push must never appear
    @(posedge clk); #1;
    mc_ce = 1'b0; mc_add = 6'h07; mc_data_in = 16'h5A5A; mc_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 mc_we = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_cmd = 8'h00;
    m_ptr = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mc_ce = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_cmd_code", cmd_code, 0);
    chk("post_rst_reg_addr", reg_addr, 0);
    chk("post_rst_fifo_data", fifo_wr_data, 0);
    chk("post_rst_cmd_data", cmd_data, 0);
    chk("post_rst_outputs", {reg_wr_stb, cmd_stb, fifo_wr_stb, trigger_stb, mc_data_oe}, 0);
    chk("post_rst_queue", expq.size(), 0);

    bus_write(6'h07, 16'h1357);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
